// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester handshakes and the scratch-memory bus.
// The arbiter connects through the slave modport; the requester/memory
// environment uses the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  // Port 0 (fetch/control path)
  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  // Port 1 (data path)
  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  // Memory side
  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  logic              busy;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  mem_data_out,
    output ack0, rdata0, ack1, rdata1,
    output mem_enable, mem_read_write, mem_address, mem_data_in,
    output busy
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output mem_data_out,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_enable, mem_read_write, mem_address, mem_data_in,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 16x8 synchronous scratch
// memory. One transaction at a time: IDLE -> ISSUE -> (CAPTURE) -> RESP.
// Every memory-side output, ack, rdata and busy come straight from flops.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              win_r, win_s;       // granted port id
  logic              rw_r, rw_s;         // latched direction
  logic [ADDR_W-1:0] addr_r, addr_s;     // latched address
  logic [DATA_W-1:0] wdata_r, wdata_s;   // latched write data
  logic              ptr_r, ptr_s;       // port favoured on a tie

  logic              mem_enable_r, mem_enable_s;
  logic              mem_rw_r, mem_rw_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_din_r, mem_din_s;
  logic              ack0_r, ack0_s;
  logic              ack1_r, ack1_s;
  logic [DATA_W-1:0] rdata0_r, rdata0_s;
  logic [DATA_W-1:0] rdata1_r, rdata1_s;
  logic              busy_r, busy_s;

  logic              grant_s;            // some port wins this IDLE cycle
  logic              pick_s;             // which port wins

  // Arbitration: a lone requester wins, a tie goes to the priority pointer.
  always_comb begin
    grant_s = 1'b0;
    pick_s  = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_s = 1'b1;
      pick_s  = ptr_r;
    end else if (bus.req0) begin
      grant_s = 1'b1;
      pick_s  = 1'b0;
    end else if (bus.req1) begin
      grant_s = 1'b1;
      pick_s  = 1'b1;
    end else begin
      grant_s = 1'b0;
      pick_s  = 1'b0;
    end
  end

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    state_s      = state_r;
    win_s        = win_r;
    rw_s         = rw_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    ptr_s        = ptr_r;
    mem_enable_s = 1'b0;
    mem_rw_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_din_s    = mem_din_r;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    rdata0_s     = rdata0_r;
    rdata1_s     = rdata1_r;

    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          win_s = pick_s;
          if (pick_s) begin
            rw_s    = bus.rw1;
            addr_s  = bus.addr1;
            wdata_s = bus.wdata1;
          end else begin
            rw_s    = bus.rw0;
            addr_s  = bus.addr0;
            wdata_s = bus.wdata0;
          end
          // Strobe is registered, so it is presented for the whole ISSUE cycle.
          mem_enable_s = 1'b1;
          mem_rw_s     = rw_s;
          mem_addr_s   = addr_s;
          mem_din_s    = wdata_s;
          state_s      = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (rw_r) begin
          // Keep direction at read so the memory holds its output for capture.
          mem_rw_s = 1'b1;
          state_s  = ST_CAPTURE;
        end else begin
          if (win_r) begin
            ack1_s = 1'b1;
          end else begin
            ack0_s = 1'b1;
          end
          state_s = ST_RESP;
        end
      end

      ST_CAPTURE: begin
        if (win_r) begin
          rdata1_s = bus.mem_data_out;
          ack1_s   = 1'b1;
        end else begin
          rdata0_s = bus.mem_data_out;
          ack0_s   = 1'b1;
        end
        state_s = ST_RESP;
      end

      ST_RESP: begin
        ptr_s   = ~win_r;
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, latched request and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      win_r        <= 1'b0;
      rw_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      ptr_r        <= 1'b0;
      mem_enable_r <= 1'b0;
      mem_rw_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_din_r    <= {DATA_W{1'b0}};
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      rdata0_r     <= {DATA_W{1'b0}};
      rdata1_r     <= {DATA_W{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      win_r        <= win_s;
      rw_r         <= rw_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      ptr_r        <= ptr_s;
      mem_enable_r <= mem_enable_s;
      mem_rw_r     <= mem_rw_s;
      mem_addr_r   <= mem_addr_s;
      mem_din_r    <= mem_din_s;
      ack0_r       <= ack0_s;
      ack1_r       <= ack1_s;
      rdata0_r     <= rdata0_s;
      rdata1_r     <= rdata1_s;
      busy_r       <= busy_s;
    end
  end

  assign bus.mem_enable     = mem_enable_r;
  assign bus.mem_read_write = mem_rw_r;
  assign bus.mem_address    = mem_addr_r;
  assign bus.mem_data_in    = mem_din_r;
  assign bus.ack0           = ack0_r;
  assign bus.ack1           = ack1_r;
  assign bus.rdata0         = rdata0_r;
  assign bus.rdata1         = rdata1_r;
  assign bus.busy           = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x8 scratch memory.
// Stimulus is driven and outputs sampled 1 ns after the falling clock edge.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;

  mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Clock: 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratch memory: registered output, zeroed while direction is write
  logic [7:0] mem_q [16];
  always @(posedge clk) begin
    if (bus.mem_enable && !bus.mem_read_write) mem_q[bus.mem_address] <= bus.mem_data_in;
    if (bus.mem_enable && bus.mem_read_write) bus.mem_data_out <= mem_q[bus.mem_address];
    else if (!bus.mem_read_write) bus.mem_data_out <= 8'h00;
  end

  // Activity counters sampled on the falling edge
  int   en_total   = 0;
  int   en_consec  = 0;
  int   ack_total  = 0;
  int   both_ack   = 0;
  logic en_prev    = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_enable) en_total <= en_total + 1;
    if (bus.mem_enable && en_prev) en_consec <= en_consec + 1;
    en_prev <= bus.mem_enable;
    if (bus.ack0 || bus.ack1) ack_total <= ack_total + 1;
    if (bus.ack0 && bus.ack1) both_ack <= both_ack + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [32:0] outs();
    return {bus.ack0, bus.ack1, bus.rdata0, bus.rdata1, bus.mem_enable,
            bus.mem_read_write, bus.mem_address, bus.mem_data_in, bus.busy};
  endfunction

  task automatic drive_req(input int port, input logic r, input logic rw,
                           input logic [3:0] a, input logic [7:0] d);
    if (port == 0) begin
      bus.req0 = r; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One transaction from IDLE: lat = falling edges until own ack (-1 on timeout),
  // iss = {busy, enable, rw, addr, din} seen in the first cycle after the grant.
  task automatic do_req(input int port, input logic rw, input logic [3:0] a,
                        input logic [7:0] d, output int lat,
                        output logic [7:0] rd, output logic [14:0] iss);
    lat = -1;
    rd  = 8'h00;
    iss = 15'h0;
    drive_req(port, 1'b1, rw, a, d);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) iss = {bus.busy, bus.mem_enable, bus.mem_read_write, bus.mem_address, bus.mem_data_in};
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) begin
        lat = i;
        rd  = (port == 0) ? bus.rdata0 : bus.rdata1;
        break;
      end
    end
    drive_req(port, 1'b0, rw, a, d);
    step();
  endtask

  task automatic test_reset();
    int lat;
    int a0;
    logic [7:0] rd;
    logic [14:0] iss;
    reset_n = 1'b0;
    step(); step();
    n_checks++;
    if (outs() !== 33'd0) $display("FAIL reset_state: got %0h expected 0", outs());
    else n_pass++;
    reset_n = 1'b1;
    step();
    // start a read, then reset in the middle of it
    drive_req(0, 1'b1, 1'b1, 4'h3, 8'h00);
    step(); step();
    a0 = ack_total;
    reset_n = 1'b0;
    drive_req(0, 1'b0, 1'b1, 4'h3, 8'h00);
    step(); step();
    n_checks++;
    if (outs() !== 33'd0) $display("FAIL reset_midop_state: got %0h expected 0", outs());
    else n_pass++;
    n_checks++;
    if (ack_total !== a0) $display("FAIL reset_midop_noack: got %0d acks expected %0d", ack_total, a0);
    else n_pass++;
    reset_n = 1'b1;
    step();
    do_req(1, 1'b0, 4'h7, 8'h42, lat, rd, iss);
    n_checks++;
    if (lat !== 2) $display("FAIL reset_next_req_latency: got %0d expected 2", lat);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int lat;
    int e0;
    logic [7:0] rd;
    logic [14:0] iss;
    e0 = en_total;
    do_req(0, 1'b0, 4'h3, 8'hA5, lat, rd, iss);
    n_checks++;
    if (lat !== 2) $display("FAIL write_latency: got %0d expected 2", lat);
    else n_pass++;
    n_checks++;
    if (iss !== {1'b1, 1'b1, 1'b0, 4'h3, 8'hA5}) $display("FAIL write_issue_bus: got %0h expected %0h", iss, {1'b1, 1'b1, 1'b0, 4'h3, 8'hA5});
    else n_pass++;
    n_checks++;
    if (en_total - e0 !== 1) $display("FAIL write_enable_cycles: got %0d expected 1", en_total - e0);
    else n_pass++;
    e0 = en_total;
    do_req(0, 1'b1, 4'h3, 8'h00, lat, rd, iss);
    n_checks++;
    if (lat !== 3) $display("FAIL read_latency: got %0d expected 3", lat);
    else n_pass++;
    n_checks++;
    if (rd !== 8'hA5) $display("FAIL read_data: got %0h expected a5", rd);
    else n_pass++;
    n_checks++;
    if (en_total - e0 !== 1) $display("FAIL read_enable_cycles: got %0d expected 1", en_total - e0);
    else n_pass++;
    // a write by the same port leaves its rdata alone
    do_req(0, 1'b0, 4'h4, 8'h5E, lat, rd, iss);
    n_checks++;
    if (bus.rdata0 !== 8'hA5) $display("FAIL write_keeps_rdata: got %0h expected a5", bus.rdata0);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0] order;
    int n;
    int both0;
    int cons0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    both0 = both_ack;
    cons0 = en_consec;
    order = 4'h0;
    n = 0;
    drive_req(0, 1'b1, 1'b0, 4'h8, 8'h80);
    drive_req(1, 1'b1, 1'b0, 4'h9, 8'h90);
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (bus.ack0) begin
        order[n[1:0]] = 1'b0;
        n++;
      end else if (bus.ack1) begin
        order[n[1:0]] = 1'b1;
        n++;
      end
    end
    drive_req(0, 1'b0, 1'b0, 4'h8, 8'h80);
    drive_req(1, 1'b0, 1'b0, 4'h9, 8'h90);
    step();
    n_checks++;
    if (n !== 4) $display("FAIL contention_ack_count: got %0d expected 4", n);
    else n_pass++;
    n_checks++;
    if (order !== 4'b1010) $display("FAIL contention_order: got %b expected 1010 (grant i in bit i)", order);
    else n_pass++;
    n_checks++;
    if (both_ack !== both0) $display("FAIL contention_dual_ack: got %0d expected %0d", both_ack, both0);
    else n_pass++;
    n_checks++;
    if (en_consec !== cons0) $display("FAIL contention_enable_run: got %0d expected %0d", en_consec, cons0);
    else n_pass++;
  endtask

  task automatic test_cross_port();
    int lat;
    logic [7:0] rd;
    logic [14:0] iss;
    do_req(1, 1'b0, 4'hF, 8'h3C, lat, rd, iss);
    n_checks++;
    if (bus.rdata1 !== 8'h00) $display("FAIL cross_write_keeps_rdata1: got %0h expected 0", bus.rdata1);
    else n_pass++;
    do_req(0, 1'b1, 4'hF, 8'h00, lat, rd, iss);
    n_checks++;
    if (rd !== 8'h3C) $display("FAIL cross_read_rdata0: got %0h expected 3c", rd);
    else n_pass++;
    n_checks++;
    if (bus.rdata1 !== 8'h00) $display("FAIL cross_rdata1_untouched: got %0h expected 0", bus.rdata1);
    else n_pass++;
    do_req(1, 1'b1, 4'h3, 8'h00, lat, rd, iss);
    n_checks++;
    if (rd !== 8'hA5) $display("FAIL cross_read_rdata1: got %0h expected a5", rd);
    else n_pass++;
    n_checks++;
    if (bus.rdata0 !== 8'h3C) $display("FAIL cross_rdata0_untouched: got %0h expected 3c", bus.rdata0);
    else n_pass++;
  endtask

  task automatic test_addr_wrap();
    int lat;
    logic [7:0] rd;
    logic [14:0] iss;
    do_req(0, 1'b0, 4'h0, 8'h5A, lat, rd, iss);
    n_checks++;
    if (iss !== {1'b1, 1'b1, 1'b0, 4'h0, 8'h5A}) $display("FAIL wrap_issue_addr0: got %0h expected %0h", iss, {1'b1, 1'b1, 1'b0, 4'h0, 8'h5A});
    else n_pass++;
    do_req(1, 1'b0, 4'hF, 8'hC3, lat, rd, iss);
    do_req(1, 1'b1, 4'h0, 8'h00, lat, rd, iss);
    n_checks++;
    if (rd !== 8'h5A) $display("FAIL wrap_read_addr0: got %0h expected 5a", rd);
    else n_pass++;
    do_req(0, 1'b1, 4'hF, 8'h00, lat, rd, iss);
    n_checks++;
    if (rd !== 8'hC3) $display("FAIL wrap_read_addrf: got %0h expected c3", rd);
    else n_pass++;
    n_checks++;
    if (iss !== {1'b1, 1'b1, 1'b1, 4'hF, 8'h00}) $display("FAIL wrap_issue_addrf: got %0h expected %0h", iss, {1'b1, 1'b1, 1'b1, 4'hF, 8'h00});
    else n_pass++;
  endtask

  task automatic test_reset_issue();
    int lat;
    int a0;
    int e0;
    logic [7:0] rd;
    logic [14:0] iss;
    do_req(0, 1'b0, 4'h5, 8'h11, lat, rd, iss);
    drive_req(0, 1'b1, 1'b0, 4'h5, 8'h77);
    step();
    n_checks++;
    if ({bus.mem_enable, bus.busy} !== 2'b11) $display("FAIL rst_issue_reached: got %b expected 11", {bus.mem_enable, bus.busy});
    else n_pass++;
    a0 = ack_total;
    e0 = en_total;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_enable, bus.busy} !== 2'b00) $display("FAIL rst_issue_async_clear: got %b expected 00", {bus.mem_enable, bus.busy});
    else n_pass++;
    drive_req(0, 1'b0, 1'b0, 4'h5, 8'h77);
    step(); step();
    reset_n = 1'b1;
    step(); step();
    n_checks++;
    if (ack_total !== a0) $display("FAIL rst_issue_noack: got %0d acks expected %0d", ack_total, a0);
    else n_pass++;
    n_checks++;
    if (en_total !== e0) $display("FAIL rst_issue_no_enable: got %0d expected %0d", en_total, e0);
    else n_pass++;
    do_req(1, 1'b1, 4'h5, 8'h00, lat, rd, iss);
    n_checks++;
    if (rd !== 8'h11) $display("FAIL rst_issue_mem_intact: got %0h expected 11", rd);
    else n_pass++;
  endtask

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    drive_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
    test_reset();
    test_write_read();
    test_contention();
    test_cross_port();
    test_addr_wrap();
    test_reset_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the 16x8 synchronous scratch memory (4-bit address, 8-bit data, mem_enable / read_write strobes).
- Lets two requesters share the memory through a req/ack handshake:
  - Port 0: fetch/control path.
  - Port 1: data path.
- Grants are round-robin, one transaction at a time.
- For each grant it drives the memory's enable/direction/address/write-data lines and, on reads, captures the memory's registered output into the granted port's read-data register.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high with rw0/addr0/wdata0 stable until ack0.
- rw0  in  1  port 0 direction: 1 = read, 0 = write.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse to port 0.
- rdata0  out  DATA_W  port 0 read data; valid when ack0 is high, held until the next port 0 read completes.
- req1, rw1, addr1, wdata1, ack1, rdata1: identical to port 0, for port 1.
- mem_enable  out  1  memory enable strobe.
- mem_read_write  out  1  memory direction: 1 = read, 0 = write.
- mem_address  out  ADDR_W  memory address.
- mem_data_in  out  DATA_W  write data to memory.
- mem_data_out  in  DATA_W  read data from memory (registered output; forced to 0 when direction is write).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, effective immediately on reset_n low):
  - State = IDLE; priority pointer = port 0.
  - mem_enable=0, mem_read_write=0, mem_address=0, mem_data_in=0.
  - ack0=ack1=0, rdata0=rdata1=0, busy=0.
- States: IDLE, ISSUE, CAPTURE, RESP. All memory-side outputs and acks are driven from registered values.
- IDLE:
  - If exactly one req is high, that port wins.
  - If both are high, the port named by the priority pointer wins.
  - On a win, latch winner id, rw, addr and wdata, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_enable=1, mem_read_write=latched rw, mem_address=latched addr, mem_data_in=latched wdata.
  - The memory performs the access at the edge that ends ISSUE.
  - Next state: CAPTURE for a read, RESP for a write.
- CAPTURE (reads only, one cycle):
  - mem_enable=0; mem_read_write held at 1 so the memory presents its output.
  - At the edge that ends CAPTURE, load mem_data_out into the winner's rdata register, then go to RESP.
- RESP (one cycle):
  - Pulse the winner's ack; the other ack stays 0.
  - mem_enable=0, mem_read_write=0.
  - Set the priority pointer to the non-winning port, then go to IDLE.
- Latency (req first sampled high in IDLE at cycle t):
  - Write: ISSUE at t+1, ack at t+2.
  - Read: ISSUE at t+1, CAPTURE at t+2, ack with valid rdata at t+3.
  - Back-to-back throughput: one write per 3 cycles, one read per 4 cycles.
- Handshake rules:
  - A requester drops req in the cycle after it sees ack. A req still high in IDLE after ack is treated as a new request.
  - Changing rw/addr/wdata while req is pending but not yet latched is allowed. Values are captured only in IDLE.
  - A req dropped before grant is simply not served. A req dropped after grant does not abort the transaction, and ack is still issued.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
- mem_enable is never high for more than one consecutive cycle, and never high outside ISSUE.
- rdata of the non-winning port is never modified. A write does not modify the winner's rdata.
- Reset asserted mid-transaction:
  - The transaction is abandoned and no ack is issued.
  - If reset_n falls during ISSUE before the rising edge, the memory sees mem_enable=0 at that edge and no access occurs.

Test Plan:
- Reset: pulse reset_n low for 2 cycles mid-operation -> all outputs 0, busy=0, no ack; the next request is served normally.
- Single write then read: port 0 writes 0xA5 to address 0x3, then reads address 0x3 -> write ack0 at t+2; read ack0 at t+3 with rdata0=0xA5; mem_enable high for exactly one cycle per transaction.
- Contention: req0 and req1 both high from reset, both doing writes, re-asserting after each ack -> grants in order 0,1,0,1; no two acks in the same cycle.
- Cross-port data: port 1 writes 0x3C to address 0xF, then port 0 reads address 0xF -> rdata0=0x3C and rdata1 unchanged.
- Address wrap: writes to addresses 0x0 and 0xF with distinct values, read both back -> values match; no aliasing.
- Reset during ISSUE of a write of 0x77 to address 0x5, with address 0x5 holding 0x11 -> no ack; a later read of address 0x5 returns 0x11.
